// File: rtl/vram_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// vram_arbiter : display-priority arbiter for a single-port VRAM with a host
// write FIFO; optional contention counter enabled by macro VRAM_STALL_CNT_EN.
// Revision 1.0
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int AW          = 14,
  parameter int DW          = 16,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_rdata,
  output logic          disp_rvalid,
  input  logic          host_wr_valid,
  output logic          host_wr_ready,
  input  logic [AW-1:0] host_wr_addr,
  input  logic [DW-1:0] host_wr_data,
  input  logic          host_rd_valid,
  output logic          host_rd_ready,
  input  logic [AW-1:0] host_rd_addr,
  output logic [DW-1:0] host_rd_data,
  output logic          host_rd_dvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_en,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt,
  input  logic          stall_clr
);
  localparam int          PW       = $clog2(WFIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(WFIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DISP_RD = 2'd1,
    ST_HOST_WR = 2'd2,
    ST_HOST_RD = 2'd3
  } acc_state_e;

  logic [AW-1:0] fifo_addr_q [WFIFO_DEPTH];
  logic [DW-1:0] fifo_data_q [WFIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          wr_ready_q, wr_ready_d;
  acc_state_e    state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_host_q, rd_host_d;

  logic fifo_empty;
  logic push;
  logic pop;
  logic rd_accept;

  always_comb begin
    fifo_empty = (count_q == '0);
    push       = rst_n && host_wr_valid && wr_ready_q;
    pop        = rst_n && !disp_req && !fifo_empty;
    // A write pushed this cycle is older than a read offered alongside it
    rd_accept  = rst_n && !disp_req && fifo_empty && !push && host_rd_valid;

    state_d     = ST_IDLE;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (rst_n && disp_req) begin
      state_d    = ST_DISP_RD;
      mem_addr_d = disp_addr;
    end else if (pop) begin
      state_d     = ST_HOST_WR;
      mem_addr_d  = fifo_addr_q[rd_ptr_q];
      mem_wdata_d = fifo_data_q[rd_ptr_q];
    end else if (rd_accept) begin
      state_d    = ST_HOST_RD;
      mem_addr_d = host_rd_addr;
    end
    mem_en_d = (state_d != ST_IDLE);
    mem_we_d = (state_d == ST_HOST_WR);

    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    wr_ready_d = (count_d != FULL_CNT);

    // The access on mem_* now returns data next cycle; the tag follows it
    rd_vld_d  = (state_q == ST_DISP_RD) || (state_q == ST_HOST_RD);
    rd_host_d = (state_q == ST_HOST_RD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ready_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_host_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ready_q  <= wr_ready_d;
      rd_vld_q    <= rd_vld_d;
      rd_host_q   <= rd_host_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= host_wr_addr;
      fifo_data_q[wr_ptr_q] <= host_wr_data;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_en         = mem_en_q;
  assign mem_we         = mem_we_q;
  assign host_wr_ready  = wr_ready_q;
  assign host_rd_ready  = rd_accept;
  assign disp_rvalid    = rd_vld_q && !rd_host_q;
  assign host_rd_dvalid = rd_vld_q && rd_host_q;
  assign disp_rdata     = disp_rvalid    ? mem_rdata : '0;
  assign host_rd_data   = host_rd_dvalid ? mem_rdata : '0;

`ifdef VRAM_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (stall_clr) begin
      stall_d = '0;
    end else if (disp_req && (!fifo_empty || host_rd_valid) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  logic unused_stall_clr;
  assign unused_stall_clr = stall_clr;
  assign stall_cnt        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_vram_arbiter : randomized self-checking bench for vram_arbiter against a
// transaction-level reference model. Revision 1.0
// -----------------------------------------------------------------------------
module tb_vram_arbiter;
  localparam int AW    = 14;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic          host_wr_valid = 1'b0;
  logic          host_wr_ready;
  logic [AW-1:0] host_wr_addr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic          host_rd_valid = 1'b0;
  logic          host_rd_ready;
  logic [AW-1:0] host_rd_addr = '0;
  logic [DW-1:0] host_rd_data;
  logic          host_rd_dvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_en;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   stall_cnt;
  logic          stall_clr = 1'b0;

  vram_arbiter #(.AW(AW), .DW(DW), .WFIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready), .host_rd_addr(host_rd_addr),
    .host_rd_data(host_rd_data), .host_rd_dvalid(host_rd_dvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  // Behavioural single-port VRAM: read data appears the cycle after the access
  logic [DW-1:0] vram [1<<AW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= vram[mem_addr];
    end
  end

  // Reference model: queue of buffered writes, queue of pending read results
  typedef struct { int due; bit host; logic [DW-1:0] data; } rd_t;
  rd_t             rq[$];
  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0]   ref_mem [1<<AW];
  int              cyc = 0;
  bit              m_prev_rst = 1'b1;
  bit              m_en = 0, m_we = 0, n_en, n_we;
  logic [AW-1:0]   m_addr = '0, n_addr;
  logic [DW-1:0]   m_wdata = '0, n_wdata;
  logic [15:0]     m_stall = '0, n_stall;
  bit              e_rd_ready;
  logic [83:0]     exp_v;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [83:0] obs_vec();
    return {host_wr_ready, host_rd_ready, mem_en, mem_we,
            (mem_en ? mem_addr : 14'h0), (mem_we ? mem_wdata : 16'h0),
            disp_rvalid, (disp_rvalid ? disp_rdata : 16'h0),
            host_rd_dvalid, (host_rd_dvalid ? host_rd_data : 16'h0), stall_cnt};
  endfunction

  // Evaluates the arbitration rules for the current cycle's inputs
  task automatic eval();
    bit dv, hv, ready, push;
    logic [DW-1:0] dd, hd;
    int sz;
    #1;
    dv = 0; hv = 0; dd = '0; hd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].host) begin hv = 1; hd = rq[0].data; end
      else            begin dv = 1; dd = rq[0].data; end
      void'(rq.pop_front());
    end
    ready = !m_prev_rst && (wq.size() < DEPTH);
    e_rd_ready = 0;
    n_en = 0; n_we = 0; n_addr = '0; n_wdata = '0; n_stall = m_stall;
    if (!rst_n) begin
      wq.delete();
      rq.delete();
      n_stall = '0;
    end else begin
      sz   = wq.size();
      push = host_wr_valid && ready;
`ifdef VRAM_STALL_CNT_EN
      if (stall_clr) n_stall = '0;
      else if (disp_req && (sz > 0 || host_rd_valid) && m_stall != 16'hFFFF) n_stall = m_stall + 16'd1;
`endif
      if (disp_req) begin
        n_en = 1; n_addr = disp_addr;
        rq.push_back('{cyc + 2, 1'b0, ref_mem[disp_addr]});
      end else if (sz > 0) begin
        n_en = 1; n_we = 1;
        {n_addr, n_wdata} = wq.pop_front();
        ref_mem[n_addr] = n_wdata;
      end else if (host_rd_valid && !push) begin
        e_rd_ready = 1; n_en = 1; n_addr = host_rd_addr;
        rq.push_back('{cyc + 2, 1'b1, ref_mem[host_rd_addr]});
      end
      if (push) wq.push_back({host_wr_addr, host_wr_data});
    end
    exp_v = {ready, e_rd_ready, m_en, m_we, (m_en ? m_addr : 14'h0), (m_we ? m_wdata : 16'h0),
             dv, dd, hv, hd, m_stall};
  endtask

  task automatic commit();
    @(posedge clk);
    m_en = n_en; m_we = n_we; m_addr = n_addr; m_wdata = n_wdata; m_stall = n_stall;
    m_prev_rst = !rst_n;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; disp_req = 1; host_wr_valid = 1; host_rd_valid = 1;
    disp_addr = 14'($urandom); host_wr_addr = 14'($urandom); host_rd_addr = 14'($urandom);
    eval(); commit();
    for (int i = 0; i < 3; i++) begin
      eval();
      n_checks++;
      if (obs_vec() !== exp_v) begin n_fail++; $display("FAIL reset_vec cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v); end
      n_checks++;
      if ({host_wr_ready, host_rd_ready, disp_rdata, disp_rvalid, host_rd_data, host_rd_dvalid,
           mem_addr, mem_wdata, mem_we, mem_en, stall_cnt} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs_zero cyc=%0d got_en=%b got_ready=%b got_addr=%h exp=0", cyc, mem_en, host_wr_ready, mem_addr);
      end
      commit();
    end
    rst_n = 1; disp_req = 0; host_wr_valid = 0; host_rd_valid = 0;
    eval();
    n_checks++;
    if (host_wr_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_first got=%b exp=0", host_wr_ready); end
    commit();
    eval();
    n_checks++;
    if (host_wr_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready_next got=%b exp=1", host_wr_ready); end
    n_checks++;
    if (obs_vec() !== exp_v) begin n_fail++; $display("FAIL release_vec cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v); end
    commit();
  endtask

  task automatic test_disp_read();
    vram[14'h0123] <= 16'hBEEF;
    ref_mem[14'h0123] = 16'hBEEF;
    disp_req = 1; disp_addr = 14'h0123;
    eval(); commit();
    disp_req = 0;
    eval();
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 14'h0123 || disp_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL disp_issue got en=%b we=%b addr=%h rv=%b exp en=1 we=0 addr=0123 rv=0", mem_en, mem_we, mem_addr, disp_rvalid);
    end
    commit();
    eval();
    n_checks++;
    if (disp_rvalid !== 1'b1 || disp_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL disp_data got rv=%b data=%h exp rv=1 data=BEEF", disp_rvalid, disp_rdata);
    end
    commit();
    eval();
    n_checks++;
    if (disp_rvalid !== 1'b0) begin n_fail++; $display("FAIL disp_pulse_len got=%b exp=0", disp_rvalid); end
    commit();
  endtask

  task automatic test_fifo_full();
    logic [AW-1:0] wa [DEPTH];
    logic [DW-1:0] wd [DEPTH];
    disp_req = 1; disp_addr = 14'($urandom);
    for (int i = 0; i < DEPTH; i++) begin
      wa[i] = 14'($urandom); wd[i] = 16'($urandom);
      host_wr_valid = 1; host_wr_addr = wa[i]; host_wr_data = wd[i];
      eval();
      n_checks++;
      if (obs_vec() !== exp_v) begin n_fail++; $display("FAIL fill_vec cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v); end
      commit();
    end
    host_wr_addr = 14'($urandom); host_wr_data = 16'($urandom);
    eval();
    n_checks++;
    if (host_wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", host_wr_ready); end
    commit();
    host_wr_valid = 0; disp_req = 0;
    eval(); commit();
    for (int i = 0; i < DEPTH; i++) begin
      eval();
      n_checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== wa[i] || mem_wdata !== wd[i]) begin
        n_fail++; $display("FAIL fifo_order idx=%0d got we=%b addr=%h data=%h exp we=1 addr=%h data=%h", i, mem_we, mem_addr, mem_wdata, wa[i], wd[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (host_wr_ready !== 1'b1) begin n_fail++; $display("FAIL ready_reassert got=%b exp=1", host_wr_ready); end
      end
      commit();
    end
  endtask

  task automatic test_raw();
    int acc = -1;
    bit got = 0;
    logic [DW-1:0] gd = '0;
    disp_req = 0;
    host_wr_valid = 1; host_wr_addr = 14'h0010; host_wr_data = 16'h5A5A;
    host_rd_valid = 1; host_rd_addr = 14'h0010;
    eval();
    n_checks++;
    if (host_rd_ready !== 1'b0) begin n_fail++; $display("FAIL raw_early_accept got=%b exp=0", host_rd_ready); end
    commit();
    host_wr_valid = 0;
    for (int k = 0; k < 10; k++) begin
      eval();
      if (host_rd_ready === 1'b1 && acc < 0) acc = k;
      if (host_rd_dvalid === 1'b1) begin got = 1; gd = host_rd_data; end
      n_checks++;
      if (obs_vec() !== exp_v) begin n_fail++; $display("FAIL raw_vec cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v); end
      commit();
      if (acc >= 0) host_rd_valid = 0;
    end
    host_rd_valid = 0;
    n_checks++;
    if (acc != 1) begin n_fail++; $display("FAIL raw_accept_cycle got=%0d exp=1", acc); end
    n_checks++;
    if (!got || gd !== 16'h5A5A) begin n_fail++; $display("FAIL raw_data got_valid=%0b data=%h exp valid=1 data=5A5A", got, gd); end
  endtask

  task automatic test_contention();
    int nd = 0, nrdy = 0, npulse = 0;
    logic [15:0] exp_stall;
    stall_clr = 1; eval(); commit(); stall_clr = 0;
    for (int i = 0; i < 10; i++) begin
      disp_req = 1; disp_addr = 14'($urandom);
      host_rd_valid = 1; host_rd_addr = 14'($urandom);
      eval();
      if (host_rd_ready !== 1'b0) nrdy++;
      if (disp_rvalid === 1'b1) npulse++;
      n_checks++;
      if (obs_vec() !== exp_v) begin n_fail++; $display("FAIL cont_vec cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v); end
      commit();
      if (mem_en === 1'b1 && mem_we === 1'b0) nd++;
    end
    disp_req = 0; host_rd_valid = 0;
`ifdef VRAM_STALL_CNT_EN
    exp_stall = 16'd10;
`else
    exp_stall = 16'd0;
`endif
    for (int i = 0; i < 3; i++) begin
      stall_clr = (i == 1);
      eval();
      if (disp_rvalid === 1'b1) npulse++;
      if (i == 0) begin
        n_checks++;
        if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL stall_count got=%0d exp=%0d", stall_cnt, exp_stall); end
      end
      if (i == 2) begin
        n_checks++;
        if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_clear got=%0d exp=0", stall_cnt); end
      end
      commit();
    end
    stall_clr = 0;
    n_checks++;
    if (nd != 10 || nrdy != 0 || npulse != 10) begin
      n_fail++; $display("FAIL contention got disp_acc=%0d rd_ready=%0d pulses=%0d exp 10/0/10", nd, nrdy, npulse);
    end
  endtask

  task automatic test_mid_reset();
    int nwe = 0, ndv = 0;
    disp_req = 1;
    for (int i = 0; i < 2; i++) begin
      host_wr_valid = 1; host_wr_addr = 14'($urandom); host_wr_data = 16'($urandom);
      eval(); commit();
    end
    host_wr_valid = 0; disp_req = 0; rst_n = 0;
    eval(); commit();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      eval();
      if (mem_we !== 1'b0) nwe++;
      if (i == 1) begin
        n_checks++;
        if (host_wr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready got=%b exp=1", host_wr_ready); end
      end
      commit();
    end
    n_checks++;
    if (nwe != 0) begin n_fail++; $display("FAIL mid_reset_fifo_flush got_writes=%0d exp=0", nwe); end
    host_rd_valid = 1; host_rd_addr = 14'($urandom);
    eval();
    n_checks++;
    if (host_rd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rd_accept got=%b exp=1", host_rd_ready); end
    commit();
    host_rd_valid = 0; rst_n = 0;
    eval(); commit();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      eval();
      if (host_rd_dvalid !== 1'b0) ndv++;
      n_checks++;
      if (obs_vec() !== exp_v) begin n_fail++; $display("FAIL mid_vec cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v); end
      commit();
    end
    n_checks++;
    if (ndv != 0) begin n_fail++; $display("FAIL mid_reset_dvalid got=%0d exp=0", ndv); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) disp_req = ~disp_req;
      disp_addr     = 14'($urandom_range(0, 15));
      host_wr_valid = $urandom_range(0, 1);
      host_wr_addr  = 14'($urandom_range(0, 15));
      host_wr_data  = 16'($urandom);
      host_rd_valid = $urandom_range(0, 1);
      host_rd_addr  = 14'($urandom_range(0, 15));
      stall_clr     = ($urandom_range(0, 31) == 0);
      eval();
      n_checks++;
      if (obs_vec() !== exp_v) begin n_fail++; $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v); end
      commit();
    end
    rst_n = 1; disp_req = 0; host_wr_valid = 0; host_rd_valid = 0; stall_clr = 0;
    for (int i = 0; i < 10; i++) begin
      eval();
      n_checks++;
      if (obs_vec() !== exp_v) begin n_fail++; $display("FAIL drain_vec cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v); end
      commit();
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      vram[i]    <= 16'(i * 40503 + 7);
      ref_mem[i]  = 16'(i * 40503 + 7);
    end
    test_reset();
    test_disp_read();
    test_fifo_full();
    test_raw();
    test_contention();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
